sram_seq_ctrl: RTL and testbench

Parametrised SRAM sequencing controller. It is the next generation of the single-pass write/read-back sequencer in the top-level design.
- A `write` pulse runs a pass that writes NUM_WORDS pattern words to consecutive addresses.
- A `read` pulse runs a pass that reads them back into a latched register.
- Phase timing (setup/strobe/hold) is parametrised and drives active-low SRAM strobes plus a data-bus drive enable.
- It sits between the test/control logic and the external SRAM; the tristate split is done outside.

---
 rtl/sram_ctrl_pkg.sv | 32 +++
 rtl/sram_phase_timer.sv | 22 ++
 rtl/sram_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_sram_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM sequencing controller: state and mode
// encodings plus the write-pattern function used by the RTL.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_WR,
    MODE_RD
  } mode_t;

  // Wide on purpose; callers truncate to DATA_W, which gives the zero-extend/truncate rule.
  function automatic logic [63:0] pattern(input logic [63:0] addr, input logic [63:0] seed);
    return addr ^ seed;
  endfunction

  function automatic int max_phase(input int a, input int b, input int c);
    int m;
    m = 1;
    if (a > m) m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Phase down-counter: loads duration-1 on phase entry and flags zero when the
// phase has run its course.
module sram_phase_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  assign zero = (value == '0);

  always_ff @(posedge clock) begin
    if (reset)      value <= '0;
    else if (load)  value <= load_val;
    else if (!zero) value <= value - 1'b1;
  end

endmodule

// File: rtl/sram_seq_ctrl.sv
// SRAM write/read-back sequencer with parametrised setup/strobe/hold timing.
// Optional SRAM_CHECK_EN adds read-back compare outputs err_count and err.
module sram_seq_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter int                NUM_WORDS = 16,
  parameter int                T_SETUP   = 1,
  parameter int                T_PULSE   = 1,
  parameter int                T_HOLD    = 1,
  parameter logic [DATA_W-1:0] SEED      = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] count,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_q,
  output logic              latch,
  output logic              de,
  output logic              n_ce,
  output logic              n_oe,
  output logic              n_we,
  output logic              busy,
  output logic              done
`ifdef SRAM_CHECK_EN
  ,
  output logic [ADDR_W:0]   err_count,
  output logic              err
`endif
);

  localparam int TW = $clog2(max_phase(T_SETUP, T_PULSE, T_HOLD)) + 1;
  localparam logic [TW-1:0] SETUP_LD = TW'(T_SETUP - 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(T_PULSE - 1);
  localparam logic [TW-1:0] HOLD_LD  = TW'((T_HOLD > 0) ? T_HOLD - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_t            state, nstate;
  mode_t             mode, nmode;
  logic [ADDR_W-1:0] ncount;
  logic              load, word_end, nbusy, nt_zero, tzero;
  logic [TW-1:0]     load_val, tval;

  assign wdata = DATA_W'(pattern(64'(count), 64'(SEED)));

  sram_phase_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .value    (tval),
    .zero     (tzero)
  );

  always_comb begin
    nstate   = state;
    nmode    = mode;
    ncount   = count;
    load     = 1'b0;
    load_val = '0;
    word_end = 1'b0;
    case (state)
      ST_IDLE: if (write || read) begin
        nstate   = ST_SETUP;
        nmode    = write ? MODE_WR : MODE_RD;
        ncount   = '0;
        load     = 1'b1;
        load_val = SETUP_LD;
      end
      ST_SETUP: if (tzero) begin
        nstate   = ST_STROBE;
        load     = 1'b1;
        load_val = PULSE_LD;
      end
      ST_STROBE: if (tzero) begin
        if (T_HOLD > 0) begin
          nstate   = ST_HOLD;
          load     = 1'b1;
          load_val = HOLD_LD;
        end else begin
          word_end = 1'b1;
        end
      end
      ST_HOLD: if (tzero) word_end = 1'b1;
      ST_DONE: nstate = ST_IDLE;
      default: nstate = ST_IDLE;
    endcase
    if (word_end) begin
      if (count == LAST) begin
        nstate = ST_DONE;
      end else begin
        nstate   = ST_SETUP;
        ncount   = count + 1'b1;
        load     = 1'b1;
        load_val = SETUP_LD;
      end
    end
  end

  assign nbusy   = (nstate == ST_SETUP) || (nstate == ST_STROBE) || (nstate == ST_HOLD);
  // Timer value seen during the coming cycle is zero -> that cycle is the last strobe cycle.
  assign nt_zero = load ? (load_val == '0) : (tval <= TW'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      mode    <= MODE_WR;
      count   <= '0;
      rdata_q <= '0;
      latch   <= 1'b0;
      de      <= 1'b0;
      n_ce    <= 1'b1;
      n_oe    <= 1'b1;
      n_we    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nstate;
      mode    <= nmode;
      count   <= ncount;
      if (latch) rdata_q <= rdata;
      latch   <= (nstate == ST_STROBE) && (nmode == MODE_RD) && nt_zero;
      de      <= nbusy && (nmode == MODE_WR);
      n_ce    <= !nbusy;
      n_we    <= !((nstate == ST_STROBE) && (nmode == MODE_WR));
      n_oe    <= !((nstate == ST_STROBE) && (nmode == MODE_RD));
      busy    <= nbusy;
      done    <= (nstate == ST_DONE);
    end
  end

`ifdef SRAM_CHECK_EN
  always_ff @(posedge clock) begin
    if (reset || ((state == ST_IDLE) && !write && read)) begin
      err_count <= '0;
      err       <= 1'b0;
    end else if (latch && (rdata != wdata)) begin
      err <= 1'b1;
      if (err_count != '1) err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Bench for sram_seq_ctrl: cycle-offset reference model plus directed and
// random stimulus; checks SRAM_CHECK_EN outputs when that macro is defined.
module tb_sram_seq_ctrl;

  localparam int AW = 4, DW = 8, N = 16;
  localparam int TS = 1, TP = 1, TH = 1, P = TS + TP + TH, NP = N * P;

  logic clock = 1'b0;
  logic reset = 1'b1, write = 1'b0, read = 1'b0;
  logic [DW-1:0] rdata;
  logic [AW-1:0] count;
  logic [DW-1:0] wdata, rdata_q;
  logic latch, de, n_ce, n_oe, n_we, busy, done;
`ifdef SRAM_CHECK_EN
  logic [AW:0] err_count;
  logic        err;
  logic [AW:0] err_count2;
  logic        err2;
`endif

  logic          write2 = 1'b0;
  logic [AW-1:0] count2;
  logic [DW-1:0] wdata2, rdata_q2;
  logic latch2, de2, n_ce2, n_oe2, n_we2, busy2, done2;

  always #5 clock = ~clock;

  sram_seq_ctrl dut (
    .clock(clock), .reset(reset), .write(write), .read(read), .rdata(rdata),
    .count(count), .wdata(wdata), .rdata_q(rdata_q), .latch(latch), .de(de),
    .n_ce(n_ce), .n_oe(n_oe), .n_we(n_we), .busy(busy), .done(done)
`ifdef SRAM_CHECK_EN
    , .err_count(err_count), .err(err)
`endif
  );

  sram_seq_ctrl #(.NUM_WORDS(1), .T_SETUP(2), .T_PULSE(3), .T_HOLD(0), .SEED(8'hA5)) dut2 (
    .clock(clock), .reset(reset), .write(write2), .read(1'b0), .rdata(8'h00),
    .count(count2), .wdata(wdata2), .rdata_q(rdata_q2), .latch(latch2), .de(de2),
    .n_ce(n_ce2), .n_oe(n_oe2), .n_we(n_we2), .busy(busy2), .done(done2)
`ifdef SRAM_CHECK_EN
    , .err_count(err_count2), .err(err2)
`endif
  );

  // Behavioural SRAM attached to the main DUT; corrupt flips word 3 on reads.
  logic [DW-1:0] sram [N];
  logic [DW-1:0] exp_mem [N];
  logic fill_req = 1'b0, corrupt = 1'b0;
  assign rdata = sram[count] ^ ((corrupt && count == 4'd3) ? 8'hFF : 8'h00);

  always @(posedge clock) begin
    if (fill_req) for (int i = 0; i < N; i++) sram[i] <= 8'hEE;
    else if (!n_ce && !n_we) sram[count] <= wdata;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: k is the cycle offset within a pass (0 = idle, 1..NP busy, NP+1 done).
  int k = 0;
  logic mrd = 1'b0;
  logic [AW-1:0] mcnt = '0;
  logic [DW-1:0] mrdq = '0;
  int merrc = 0;
  logic merr = 1'b0;

  function automatic int wrd(input int kk); return (kk - 1) / P; endfunction
  function automatic int pos(input int kk); return (kk - 1) % P; endfunction
  function automatic logic [DW-1:0] pat(input int a); return a[DW-1:0]; endfunction
  function automatic logic [DW-1:0] corr(input int w, input logic c);
    return (c && w == 3) ? 8'hFF : 8'h00;
  endfunction

  always @(posedge clock) begin
    if (fill_req) for (int i = 0; i < N; i++) exp_mem[i] <= 8'hEE;
    if (k >= 1 && k <= NP && !mrd && pos(k) == TS + TP - 1) exp_mem[wrd(k)] <= pat(wrd(k));
    if (reset) begin
      k <= 0; mcnt <= '0; mrdq <= '0; merr <= 1'b0; merrc <= 0;
    end else if (k == 0) begin
      if (write) begin
        k <= 1; mrd <= 1'b0; mcnt <= '0;
      end else if (read) begin
        k <= 1; mrd <= 1'b1; mcnt <= '0; merr <= 1'b0; merrc <= 0;
      end
    end else if (k == NP + 1) begin
      k <= 0;
    end else begin
      if (mrd && pos(k) == TS + TP - 1) begin
        mrdq <= exp_mem[wrd(k)] ^ corr(wrd(k), corrupt);
        if ((exp_mem[wrd(k)] ^ corr(wrd(k), corrupt)) != pat(wrd(k))) begin
          merr <= 1'b1;
          if (merrc < (1 << (AW + 1)) - 1) merrc <= merrc + 1;
        end
      end
      k <= k + 1;
      mcnt <= (k + 1 <= NP) ? AW'(wrd(k + 1)) : AW'(N - 1);
    end
  end

  logic eb, ed, es, el;
  logic [26:0] av, ev;
  always @(negedge clock) begin
    eb = (k >= 1) && (k <= NP);
    ed = (k == NP + 1);
    es = eb && pos(k) >= TS && pos(k) < TS + TP;
    el = eb && mrd && pos(k) == TS + TP - 1;
    av = {busy, done, n_ce, n_we, n_oe, de, latch, count, wdata, rdata_q};
    ev = {eb, ed, !eb, !(es && !mrd), !(es && mrd), eb && !mrd, el, mcnt, pat(int'(mcnt)), mrdq};
    chk("outputs{busy,done,n_ce,n_we,n_oe,de,latch,count,wdata,rdata_q}", 64'(av), 64'(ev));
`ifdef SRAM_CHECK_EN
    chk("err{count,flag}", 64'({err_count, err}), 64'({merrc[AW:0], merr}));
`endif
  end

  int cyc = 0, nwe_n = 0, noe_n = 0, lat_n = 0, de_n = 0;
  logic prev_lat = 1'b0;
  logic [DW-1:0] rq[$];

  task automatic tick();
    @(negedge clock);
    cyc++;
    nwe_n += int'(!n_we);
    noe_n += int'(!n_oe);
    lat_n += int'(latch);
    de_n  += int'(de);
    if (prev_lat) rq.push_back(rdata_q);
    prev_lat = latch;
  endtask

  task automatic clr();
    nwe_n = 0; noe_n = 0; lat_n = 0; de_n = 0; rq.delete();
  endtask

  task automatic wait_done(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      if (done) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic pass(input logic wr);
    int at;
    tick();
    if (wr) write = 1'b1; else read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    wait_done(200, at);
    tick();
  endtask

  initial begin
    int bc, dc;
    logic [7:0] nwe_m, busy_m, done_m;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_state", 64'({busy, done, n_ce, n_we, n_oe, de, latch, count, rdata_q}),
        64'({7'b0011100, 4'h0, 8'h00}));

    // 1: default write pass
    clr();
    write = 1'b1; tick(); write = 1'b0;
    bc = cyc;
    chk("t1_busy_rise", 64'(busy), 1);
    wait_done(200, dc);
    chk("t1_done_offset", 64'(dc - bc), 48);
    chk("t1_nwe_pulses", 64'(nwe_n), 16);

    // 2: read back
    tick(); clr();
    read = 1'b1; tick(); read = 1'b0;
    wait_done(200, dc);
    tick();
    chk("t2_noe_cycles", 64'(noe_n), 16);
    chk("t2_latch_pulses", 64'(lat_n), 16);
    chk("t2_de_cycles", 64'(de_n), 0);
    chk("t2_rq_len", 64'(rq.size()), 16);
    for (int i = 0; i < 16 && i < rq.size(); i++) chk("t2_rdata_q_seq", 64'(rq[i]), 64'(i));

    // 3: simultaneous start, then read mid-pass
    clr();
    write = 1'b1; read = 1'b1; tick(); write = 1'b0; read = 1'b0;
    repeat (21) tick();
    chk("t3_word7", 64'(count), 7);
    read = 1'b1; tick(); read = 1'b0;
    wait_done(200, dc);
    repeat (10) tick();
    chk("t3_noe_cycles", 64'(noe_n), 0);
    chk("t3_nwe_cycles", 64'(nwe_n), 16);
    chk("t3_idle", 64'(busy), 0);

    // 4: reset during word 5 strobe
    fill_req = 1'b1; tick(); fill_req = 1'b0;
    write = 1'b1; tick(); write = 1'b0;
    repeat (16) tick();
    chk("t4_in_strobe", 64'({n_we, count}), 64'({1'b0, 4'd5}));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t4_after_reset", 64'({n_ce, n_we, de, count, busy}), 64'({3'b110, 4'd0, 1'b0}));
    tick();
    for (int i = 0; i < N; i++) chk("t4_sram_word", 64'(sram[i]), (i <= 5) ? 64'(i) : 64'hEE);

    // 5: second instance, single word with long phases
    nwe_m = '0; busy_m = '0; done_m = '0;
    write2 = 1'b1; tick(); write2 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      nwe_m[c] = !n_we2;
      busy_m[c] = busy2;
      done_m[c] = done2;
      if (c == 3) chk("t5_wdata", 64'(wdata2), 64'hA5);
      tick();
    end
    chk("t5_nwe_cycles", 64'(nwe_m), 64'h38);
    chk("t5_busy_cycles", 64'(busy_m), 64'h3E);
    chk("t5_done_cycle", 64'(done_m), 64'h40);

    // 6: rewrite memory, corrupted read then clean read
    pass(1'b1);
    corrupt = 1'b1;
    pass(1'b0);
    corrupt = 1'b0;
`ifdef SRAM_CHECK_EN
    chk("t6_err_after_bad", 64'({err_count, err}), 64'({5'd1, 1'b1}));
`endif
    pass(1'b0);
`ifdef SRAM_CHECK_EN
    chk("t6_err_after_clean", 64'({err_count, err}), 64'({5'd0, 1'b0}));
`endif
    chk("t6_rdata_q_last", 64'(rdata_q), 64'h0F);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom % 97) == 0;
      write   = ($urandom % 10) == 0;
      read    = ($urandom % 10) == 0;
      corrupt = ($urandom % 2) == 0;
      tick();
    end
    reset = 1'b0; write = 1'b0; read = 1'b0; corrupt = 1'b0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
